// File: rtl/pipe_stage_skid.sv
// Pipeline stage buffer with a two-entry skid (main + skid register).
// Carries an opaque payload across a valid/ready handshake. in_ready is
// registered (derived only from state), so downstream can stall without
// creating a combinational ready path back to upstream. Also provides
// flush-to-bubble, an optional zero-on-invalid output and a saturating
// stall counter for performance monitoring.
module pipe_stage_skid #(
   parameter int DATA_W          = 76,
   parameter int ZERO_ON_INVALID = 1,
   parameter int CNT_W           = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   // Occupancy encoded directly as state: EMPTY, ONE (main valid),
   // FULL (main and skid valid).
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } stateT;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   stateT             state_q, state_d;
   logic [DATA_W-1:0] mainData_q, mainData_d;
   logic [DATA_W-1:0] skidData_q, skidData_d;
   logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;

   logic accept;
   logic emit;
   logic stalled;

   // Handshake outputs depend only on the state register, never on
   // out_ready, which keeps in_ready free of combinational paths.
   always_comb begin
      in_ready  = (state_q != FULL);
      out_valid = (state_q != EMPTY);
      accept    = in_valid & in_ready;
      emit      = out_valid & out_ready;
      stalled   = out_valid & ~out_ready;
      unique case (state_q)
         EMPTY:   occupancy = 2'd0;
         ONE:     occupancy = 2'd1;
         FULL:    occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
   end

   // Output payload: when the zero-on-invalid mode is selected, a bubble
   // shows all zeros so downstream never sees stale main contents.
   always_comb begin
      if ((ZERO_ON_INVALID != 0) && (state_q == EMPTY)) begin
         out_data = '0;
      end else begin
         out_data = mainData_q;
      end
   end

   // Next-state and payload steering. A beat accepted while ONE and not
   // emitting parks in the skid register; on the emit from FULL the skid
   // entry slides into main, keeping strict FIFO order. Flush forces a
   // bubble and drops whatever would have been loaded this cycle.
   always_comb begin
      state_d    = state_q;
      mainData_d = mainData_q;
      skidData_d = skidData_q;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d    = ONE;
               mainData_d = in_data;
            end
         end
         ONE: begin
            if (accept && emit) begin
               mainData_d = in_data;
            end else if (accept) begin
               state_d    = FULL;
               skidData_d = in_data;
            end else if (emit) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (emit) begin
               state_d    = ONE;
               mainData_d = skidData_q;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
      if (flush) begin
         state_d    = EMPTY;
         mainData_d = mainData_q;
         skidData_d = skidData_q;
      end
   end

   // Stall counter counts cycles where a held beat is refused downstream,
   // sticking at its maximum instead of wrapping. Flush does not touch it.
   always_comb begin
      stallCnt_d = stallCnt_q;
      if (stalled && (stallCnt_q != CNT_MAX)) begin
         stallCnt_d = stallCnt_q + 1'b1;
      end
   end

   // State, payload and counter registers; reset clears everything and
   // takes precedence over flush.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= EMPTY;
         mainData_q <= '0;
         skidData_q <= '0;
         stallCnt_q <= '0;
      end else begin
         state_q    <= state_d;
         mainData_q <= mainData_d;
         skidData_q <= skidData_d;
         stallCnt_q <= stallCnt_d;
      end
   end

   assign stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid. Three instances share one stimulus:
// A is the default build, B has zero-on-invalid disabled, C has a 4-bit
// stall counter so saturation can be reached quickly.
module tb_pipe_stage_skid;

   localparam int DW = 76;

   logic          clk = 1'b0;
   logic          reset;
   logic          flush;
   logic          inValid;
   logic [DW-1:0] inData;
   logic          outReady;

   logic          aInReady, aOutValid;
   logic [DW-1:0] aOutData;
   logic [1:0]    aOcc;
   logic [15:0]   aStallCnt;

   logic          bInReady, bOutValid;
   logic [DW-1:0] bOutData;
   logic [1:0]    bOcc;
   logic [15:0]   bStallCnt;

   logic          cInReady, cOutValid;
   logic [DW-1:0] cOutData;
   logic [1:0]    cOcc;
   logic [3:0]    cStallCnt;

   int vectors = 0;
   int miscompares = 0;
   int expStall = 0;

   pipe_stage_skid #(.DATA_W(DW), .ZERO_ON_INVALID(1), .CNT_W(16)) dutA (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(inValid), .in_ready(aInReady), .in_data(inData),
      .out_valid(aOutValid), .out_ready(outReady), .out_data(aOutData),
      .occupancy(aOcc), .stall_cnt(aStallCnt)
   );

   pipe_stage_skid #(.DATA_W(DW), .ZERO_ON_INVALID(0), .CNT_W(16)) dutB (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(inValid), .in_ready(bInReady), .in_data(inData),
      .out_valid(bOutValid), .out_ready(outReady), .out_data(bOutData),
      .occupancy(bOcc), .stall_cnt(bStallCnt)
   );

   pipe_stage_skid #(.DATA_W(DW), .ZERO_ON_INVALID(1), .CNT_W(4)) dutC (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(inValid), .in_ready(cInReady), .in_data(inData),
      .out_valid(cOutValid), .out_ready(outReady), .out_data(cOutData),
      .occupancy(cOcc), .stall_cnt(cStallCnt)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Drive one cycle of inputs, clock it in, and settle 1 ns past the edge
   // so the checks that follow see the post-edge register state.
   task automatic applyStimulus(input logic v, input logic [DW-1:0] d,
                                input logic r, input logic f);
      inValid  = v;
      inData   = d;
      outReady = r;
      flush    = f;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      vectors++; if (aOutValid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid got %0b want 0", aOutValid); end
      vectors++; if (aInReady !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready got %0b want 1", aInReady); end
      vectors++; if (aOcc !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_occupancy got %0d want 0", aOcc); end
      vectors++; if (aOutData !== '0) begin miscompares++; $display("[TB] FAIL reset_out_data_a got %h want 0", aOutData); end
      vectors++; if (bOutData !== '0) begin miscompares++; $display("[TB] FAIL reset_out_data_b got %h want 0", bOutData); end
      vectors++; if (aStallCnt !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_stall_cnt got %0d want 0", aStallCnt); end
      reset = 1'b0;
      expStall = 0;
   endtask

   task automatic test_streaming();
      logic [DW-1:0] d;
      for (int i = 1; i <= 6; i++) begin
         d = DW'(i);
         applyStimulus(1'b1, d, 1'b1, 1'b0);
         vectors++; if (aOutValid !== 1'b1) begin miscompares++; $display("[TB] FAIL stream_valid[%0d] got %0b want 1", i, aOutValid); end
         vectors++; if (aOutData !== d) begin miscompares++; $display("[TB] FAIL stream_data[%0d] got %h want %h", i, aOutData, d); end
         vectors++; if (aInReady !== 1'b1) begin miscompares++; $display("[TB] FAIL stream_in_ready[%0d] got %0b want 1", i, aInReady); end
         vectors++; if (aOcc !== 2'd1) begin miscompares++; $display("[TB] FAIL stream_occ[%0d] got %0d want 1", i, aOcc); end
      end
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      vectors++; if (aOutValid !== 1'b0) begin miscompares++; $display("[TB] FAIL stream_drain_valid got %0b want 0", aOutValid); end
      vectors++; if (aStallCnt !== 16'd0) begin miscompares++; $display("[TB] FAIL stream_stall got %0d want 0", aStallCnt); end
   endtask

   task automatic test_backpressure();
      applyStimulus(1'b1, DW'(32'hA), 1'b0, 1'b0);
      vectors++; if (aOcc !== 2'd1) begin miscompares++; $display("[TB] FAIL bp_occ1 got %0d want 1", aOcc); end
      vectors++; if (aStallCnt !== 16'd0) begin miscompares++; $display("[TB] FAIL bp_stall0 got %0d want 0", aStallCnt); end
      applyStimulus(1'b1, DW'(32'hB), 1'b0, 1'b0);
      expStall = 1;
      vectors++; if (aOcc !== 2'd2) begin miscompares++; $display("[TB] FAIL bp_occ2 got %0d want 2", aOcc); end
      vectors++; if (aInReady !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_in_ready got %0b want 0", aInReady); end
      vectors++; if (aOutData !== DW'(32'hA)) begin miscompares++; $display("[TB] FAIL bp_head got %h want a", aOutData); end
      vectors++; if (aStallCnt !== 16'(expStall)) begin miscompares++; $display("[TB] FAIL bp_stall1 got %0d want %0d", aStallCnt, expStall); end
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, '0, 1'b0, 1'b0);
         expStall++;
         vectors++; if (aStallCnt !== 16'(expStall)) begin miscompares++; $display("[TB] FAIL bp_stall_hold got %0d want %0d", aStallCnt, expStall); end
         vectors++; if (aOutData !== DW'(32'hA)) begin miscompares++; $display("[TB] FAIL bp_head_hold got %h want a", aOutData); end
      end
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      vectors++; if (aOutData !== DW'(32'hB)) begin miscompares++; $display("[TB] FAIL bp_second got %h want b", aOutData); end
      vectors++; if (aInReady !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_ready_back got %0b want 1", aInReady); end
      vectors++; if (aOcc !== 2'd1) begin miscompares++; $display("[TB] FAIL bp_occ_after got %0d want 1", aOcc); end
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      vectors++; if (aOutValid !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_empty got %0b want 0", aOutValid); end
      vectors++; if (aStallCnt !== 16'(expStall)) begin miscompares++; $display("[TB] FAIL bp_stall_final got %0d want %0d", aStallCnt, expStall); end
   endtask

   task automatic test_flush_full();
      applyStimulus(1'b1, DW'(32'h11), 1'b0, 1'b0);
      applyStimulus(1'b1, DW'(32'h22), 1'b0, 1'b0);
      expStall++;
      vectors++; if (aOcc !== 2'd2) begin miscompares++; $display("[TB] FAIL flush_prefill got %0d want 2", aOcc); end
      // the flush cycle itself is still a stalled cycle, so it is counted
      applyStimulus(1'b1, DW'(32'hC), 1'b0, 1'b1);
      expStall++;
      vectors++; if (aOcc !== 2'd0) begin miscompares++; $display("[TB] FAIL flush_occ got %0d want 0", aOcc); end
      vectors++; if (aOutValid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_valid got %0b want 0", aOutValid); end
      vectors++; if (aOutData !== '0) begin miscompares++; $display("[TB] FAIL flush_data got %h want 0", aOutData); end
      vectors++; if (aInReady !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_in_ready got %0b want 1", aInReady); end
      vectors++; if (aStallCnt !== 16'(expStall)) begin miscompares++; $display("[TB] FAIL flush_stall got %0d want %0d", aStallCnt, expStall); end
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      vectors++; if (aOutValid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_no_ghost got %0b want 0", aOutValid); end
      vectors++; if (aStallCnt !== 16'(expStall)) begin miscompares++; $display("[TB] FAIL flush_stall_keep got %0d want %0d", aStallCnt, expStall); end
      applyStimulus(1'b1, DW'(32'h33), 1'b1, 1'b0);
      vectors++; if (aOutData !== DW'(32'h33)) begin miscompares++; $display("[TB] FAIL flush_next_beat got %h want 33", aOutData); end
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
   endtask

   task automatic test_zero_on_invalid_off();
      applyStimulus(1'b1, DW'(32'h5), 1'b1, 1'b0);
      vectors++; if (bOutData !== DW'(32'h5)) begin miscompares++; $display("[TB] FAIL zoi_load got %h want 5", bOutData); end
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      vectors++; if (bOutValid !== 1'b0) begin miscompares++; $display("[TB] FAIL zoi_empty got %0b want 0", bOutValid); end
      vectors++; if (bOutData !== DW'(32'h5)) begin miscompares++; $display("[TB] FAIL zoi_hold got %h want 5", bOutData); end
      vectors++; if (aOutData !== '0) begin miscompares++; $display("[TB] FAIL zoi_on_zero got %h want 0", aOutData); end
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      vectors++; if (bOutData !== DW'(32'h5)) begin miscompares++; $display("[TB] FAIL zoi_hold2 got %h want 5", bOutData); end
   endtask

   task automatic test_saturation();
      logic [3:0] cExp;
      applyStimulus(1'b1, DW'(32'h7), 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, '0, 1'b0, 1'b0);
         expStall++;
         if (i == 9 || i == 19) begin
            cExp = (expStall > 15) ? 4'd15 : 4'(expStall);
            vectors++; if (cStallCnt !== cExp) begin miscompares++; $display("[TB] FAIL sat_cnt4[%0d] got %0d want %0d", i, cStallCnt, cExp); end
         end
      end
      vectors++; if (cStallCnt !== 4'd15) begin miscompares++; $display("[TB] FAIL sat_final got %0d want 15", cStallCnt); end
      vectors++; if (aStallCnt !== 16'(expStall)) begin miscompares++; $display("[TB] FAIL sat_wide got %0d want %0d", aStallCnt, expStall); end
      vectors++; if (aOutData !== DW'(32'h7)) begin miscompares++; $display("[TB] FAIL sat_head got %h want 7", aOutData); end
   endtask

   task automatic test_reset_mid();
      reset = 1'b1;
      applyStimulus(1'b1, DW'(32'h99), 1'b0, 1'b1);
      vectors++; if (aOcc !== 2'd0) begin miscompares++; $display("[TB] FAIL rmid_occ got %0d want 0", aOcc); end
      vectors++; if (aStallCnt !== 16'd0) begin miscompares++; $display("[TB] FAIL rmid_stall got %0d want 0", aStallCnt); end
      vectors++; if (cStallCnt !== 4'd0) begin miscompares++; $display("[TB] FAIL rmid_stall4 got %0d want 0", cStallCnt); end
      vectors++; if (aInReady !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_in_ready got %0b want 1", aInReady); end
      vectors++; if (aOutData !== '0) begin miscompares++; $display("[TB] FAIL rmid_data_a got %h want 0", aOutData); end
      vectors++; if (bOutData !== '0) begin miscompares++; $display("[TB] FAIL rmid_data_b got %h want 0", bOutData); end
      reset = 1'b0;
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      vectors++; if (aOutValid !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_after got %0b want 0", aOutValid); end
   endtask

   initial begin
      reset    = 1'b1;
      flush    = 1'b0;
      inValid  = 1'b0;
      inData   = '0;
      outReady = 1'b0;
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush_full();
      test_zero_on_invalid_off();
      test_saturation();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
